snake_move_ticker: RTL and testbench
====================================

// Module: snake_move_ticker
// PURPOSE
//  Upstream pacing stage for the snake movement controller. Synchronises the four direction
//  keys and a pause key, holds the committed heading, and issues a one-cycle go pulse per move
//  step while the controller reports ready (sitting in WAIT). Step period shrinks as the snake
//  grows. Freezes permanently on a collision (dead) until reset.
// PARAMETERS
//  BASE_DIV   12_500_000  step period in clk cycles at length 0
//  STEP_DIV   100_000     period reduction per unit of length
//  MIN_DIV    2_500_000   lower bound of step period (must be >= 2)
//  DIV_W      26          divider width; must hold BASE_DIV
// PORTS
//  clk        in   1      system clock
//  rst        in   1      asynchronous, active-high reset
//  key_up     in   1      async, active-high direction request
//  key_down   in   1      "
//  key_left   in   1      "
//  key_right  in   1      "
//  key_pause  in   1      async, active-high; rising edge toggles pause
//  length     in   11     current snake length (same value the movement controller uses)
//  ready      in   1      movement controller is in WAIT and samples go this cycle
//  dead       in   1      collision detected; level, sampled every cycle
//  go         out  1      one-cycle move strobe; only ever high when ready is high
//  dir        out  2      committed heading; changes only in the cycle go is high
//  paused     out  1      high while in PAUSED
//  game_over  out  1      high while in OVER
// BEHAVIOUR
//  Reset values: go=0, dir=DIR_RIGHT, paused=0, game_over=0, state=IDLE, divider=0, pending=0,
//   next_dir=DIR_RIGHT. All key and pause inputs pass through 2-flop synchronisers.
//  next_dir: each cycle the highest-priority held key wins (up>down>left>right). It is loaded
//   only if the key's code != (dir ^ 2'b01), i.e. it is not the reverse of the committed dir.
//   A reverse request is dropped. With no key held, next_dir keeps its value.
//  States:
//   IDLE   -> RUN on the first synchronised key press of any direction; divider loads the period.
//   RUN    -> divider counts down. At 0 it reloads the period and sets pending.
//             If pending is already set, the new tick is absorbed: no accumulation.
//             If pending && ready: go=1 for one cycle, dir<=next_dir on the same edge, pending<=0.
//             A pause rising edge moves to PAUSED.
//   PAUSED -> divider and pending hold. go=0. Keys still update next_dir.
//             A pause rising edge returns to RUN and the count resumes where it stopped.
//   OVER   -> entered from any state when dead=1. go=0, game_over=1, pending<=0.
//             Exit is by rst only.
//  Priority in one cycle: dead > pause edge > go issue.
//   A go already pending while a pause edge arrives is held, not issued.
//  Period = max(BASE_DIV - length*STEP_DIV, MIN_DIV). Compute the product at DIV_W+11 bits.
//   Treat any underflow as MIN_DIV. The period is sampled at each reload; a length change
//   mid-count takes effect on the next reload.
//  Latency: go rises combinationally from registered pending AND ready, so it is zero-cycle
//   relative to ready. dir is registered and valid from the cycle after go.
//  Reset mid-operation: all state returns to reset values asynchronously. Any go pulse in
//   flight is cut.
// STRUCTURE
//  Shared package snake_pkg:
//   - DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3 (reverse = code ^ 2'b01)
//   - state encodings IDLE/RUN/PAUSED/OVER
//  One sub-module: key_sync_edge, a 2-flop synchroniser plus rising-edge detector.
//   Instantiate it five times; use the edge output for pause only.
// TESTING (BASE_DIV=20, STEP_DIV=2, MIN_DIV=4, ready tied high unless noted)
//  1 Reset, no keys for 100 cycles -> go never pulses, dir=3, state IDLE.
//    Press key_up -> first go about 20 cycles later, dir=0.
//  2 Run with dir=DIR_RIGHT, press key_left only -> dir stays 3 on every go.
//    Press key_up and key_left together -> dir becomes 0 on the next go.
//  3 length=0, then 5, then 9 -> go spacing 20, then 10, then 4 (floored).
//    Change length mid-count -> old spacing finishes once, new spacing follows.
//  4 Hold ready=0 across 3 divider expiries, then raise ready -> exactly one go pulse,
//    coincident with ready.
//  5 Pause edge at divider=7 -> no go for 50 cycles. Second pause edge -> next go 7 cycles later.
//  6 Assert dead during PAUSED -> game_over=1 and go stays 0 despite keys and pause edges.
//    Assert rst -> all outputs return to reset values on the same cycle.

Source files
------------

// File: rtl/snake_move_ticker_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake movement pacing logic.
//   dir_e    : heading codes; the reverse of a heading is its code XOR 2'b01
//   state_e  : pacing FSM states
//   reverseDir(): helper returning the opposite heading
// ---------------------------------------------------------------------------
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    // Opposite heading: up<->down and left<->right differ only in bit 0
    function automatic dir_e reverseDir(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_move_ticker_if.sv
// ---------------------------------------------------------------------------
// snake_move_ticker_if
// Bundles the key inputs, controller handshake and status outputs of the
// pacing stage.
//   key_up/down/left/right/pause : raw asynchronous key levels
//   length                       : current snake length
//   ready                        : movement controller samples go this cycle
//   dead                         : collision level
//   go                           : one-cycle move strobe
//   dir                          : committed heading
//   paused / game_over           : status flags
// master drives keys and controller status; slave is the pacing stage.
// ---------------------------------------------------------------------------
interface snake_move_ticker_if;
    import snake_pkg::*;

    logic        key_up;
    logic        key_down;
    logic        key_left;
    logic        key_right;
    logic        key_pause;
    logic [10:0] length;
    logic        ready;
    logic        dead;
    logic        go;
    dir_e        dir;
    logic        paused;
    logic        game_over;

    modport master (
        output key_up, key_down, key_left, key_right, key_pause,
        output length, ready, dead,
        input  go, dir, paused, game_over
    );

    modport slave (
        input  key_up, key_down, key_left, key_right, key_pause,
        input  length, ready, dead,
        output go, dir, paused, game_over
    );

endinterface

// File: rtl/snake_move_ticker_key_sync.sv
// ---------------------------------------------------------------------------
// key_sync_edge
// Two-flop synchroniser for one asynchronous key, plus a rising-edge detector
// on the synchronised level.
//   clk, rst : clock and asynchronous active-high reset
//   async_i  : raw key level
//   sync_o   : synchronised key level
//   rise_o   : high for one cycle when sync_o goes 0 -> 1
// ---------------------------------------------------------------------------
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Two synchroniser stages followed by a delayed copy used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/snake_move_ticker.sv
// ---------------------------------------------------------------------------
// snake_move_ticker
// Pacing stage for the snake movement controller. Synchronises the keys,
// tracks the requested heading, and issues one go strobe per move step while
// the controller is ready. The step period shrinks with snake length down to
// a floor, pause toggles on a pause-key edge, and a collision freezes the
// block until reset.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : snake_move_ticker_if slave (keys, length, ready, dead in;
//              go, dir, paused, game_over out)
// ---------------------------------------------------------------------------
module snake_move_ticker
    import snake_pkg::*;
#(
    parameter int unsigned BASE_DIV = 12_500_000,
    parameter int unsigned STEP_DIV = 100_000,
    parameter int unsigned MIN_DIV  = 2_500_000,
    parameter int unsigned DIV_W    = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    snake_move_ticker_if.slave   bus
);

    localparam int unsigned PROD_W = DIV_W + 11;
    localparam logic [PROD_W-1:0] BASE_EXT = PROD_W'(BASE_DIV);
    localparam logic [PROD_W-1:0] MIN_EXT  = PROD_W'(MIN_DIV);

    logic [4:0]       keyRaw;
    logic [3:0]       keySync;
    logic [3:0]       keyRise;
    logic             unusedPauseLevel;
    logic             pauseRise;

    state_e           state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             pending_q;
    logic             pending_d;
    dir_e             dir_q;
    dir_e             nextDir_q;
    logic             paused_q;
    logic             gameOver_q;

    logic [PROD_W-1:0] stepProd;
    logic [DIV_W-1:0]  period;
    dir_e              keyDir;
    logic              keyHeld;
    logic              runCount;
    logic              tick;
    logic              goLive;

    assign keyRaw = {bus.key_pause, bus.key_right, bus.key_left, bus.key_down, bus.key_up};

    // Direction keys: level feeds heading selection, edge wakes the block from IDLE
    for (genvar k = 0; k < 4; k++) begin : g_dirSync
        key_sync_edge u_sync (
            .clk     (clk),
            .rst     (rst),
            .async_i (keyRaw[k]),
            .sync_o  (keySync[k]),
            .rise_o  (keyRise[k])
        );
    end

    // Pause acts only on its rising edge; the synchronised level is not needed
    key_sync_edge u_pauseSync (
        .clk     (clk),
        .rst     (rst),
        .async_i (keyRaw[4]),
        .sync_o  (unusedPauseLevel),
        .rise_o  (pauseRise)
    );

    // Step period: length-scaled reduction computed wide enough that it cannot
    // wrap, then clamped to the floor when it would go below it or underflow
    assign stepProd = PROD_W'(bus.length) * PROD_W'(STEP_DIV);

    always_comb begin
        period = DIV_W'(MIN_DIV);
        if ((stepProd < BASE_EXT) && ((BASE_EXT - stepProd) > MIN_EXT)) begin
            period = DIV_W'(BASE_EXT - stepProd);
        end
    end

    // Highest-priority held key: up beats down beats left beats right
    always_comb begin
        keyHeld = |keySync;
        keyDir  = DIR_RIGHT;
        if (keySync[0]) begin
            keyDir = DIR_UP;
        end else if (keySync[1]) begin
            keyDir = DIR_DOWN;
        end else if (keySync[2]) begin
            keyDir = DIR_LEFT;
        end
    end

    // The divider advances on running cycles; a pause edge freezes the cycle
    // it arrives in, while the resume edge cycle already counts. The reload
    // happens on the cycle the count would reach zero so go spacing equals
    // the period exactly. A go in the same cycle as a fresh tick keeps the
    // new tick pending rather than dropping it.
    always_comb begin
        runCount  = !bus.dead && (((state_q == ST_RUN) && !pauseRise) ||
                                  ((state_q == ST_PAUSED) && pauseRise));
        tick      = runCount && (div_q <= DIV_W'(1));
        goLive    = (state_q == ST_RUN) && pending_q && bus.ready && !bus.dead && !pauseRise;
        div_d     = tick ? period : (div_q - DIV_W'(1));
        pending_d = tick | (pending_q & ~goLive);
    end

    // Pacing FSM with registered status outputs. Collision overrides
    // everything, then a pause edge, then go issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            pending_q  <= 1'b0;
            dir_q      <= DIR_RIGHT;
            nextDir_q  <= DIR_RIGHT;
            paused_q   <= 1'b0;
            gameOver_q <= 1'b0;
        end else begin
            if (keyHeld && (keyDir != reverseDir(dir_q))) begin
                nextDir_q <= keyDir;
            end

            if (bus.dead) begin
                state_q    <= ST_OVER;
                pending_q  <= 1'b0;
                paused_q   <= 1'b0;
                gameOver_q <= 1'b1;
            end else begin
                if (runCount) begin
                    div_q     <= div_d;
                    pending_q <= pending_d;
                end
                if (goLive) begin
                    dir_q <= nextDir_q;
                end

                case (state_q)
                    ST_IDLE: begin
                        if (|keyRise) begin
                            state_q <= ST_RUN;
                            div_q   <= period;
                        end
                    end
                    ST_RUN: begin
                        if (pauseRise) begin
                            state_q  <= ST_PAUSED;
                            paused_q <= 1'b1;
                        end
                    end
                    ST_PAUSED: begin
                        if (pauseRise) begin
                            state_q  <= ST_RUN;
                            paused_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= ST_OVER;
                        gameOver_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.go        = goLive;
    assign bus.dir       = dir_q;
    assign bus.paused    = paused_q;
    assign bus.game_over = gameOver_q;

endmodule

// File: tb/tb_snake_move_ticker.sv
// ---------------------------------------------------------------------------
// tb_snake_move_ticker
// Directed bench for snake_move_ticker with BASE_DIV=20, STEP_DIV=2, MIN_DIV=4.
// Stimulus pushes the expected go events (heading and spacing window) into a
// scoreboard queue; a negedge monitor pops one entry per go pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snake_move_ticker;
    import snake_pkg::*;

    typedef struct {
        logic [1:0] dir;
        int         refCyc;
        int         lo;
        int         hi;
    } goExp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     testsRun = 0;
    int     testsFailed = 0;
    int     goCount = 0;
    int     lastGoCyc = 0;
    logic   dirCheckDue = 1'b0;
    logic [1:0] dueDir = 2'd0;
    goExp_t sbQ[$];
    goExp_t expItem;
    int     refC;

    snake_move_ticker_if ifc ();

    snake_move_ticker #(
        .BASE_DIV (20),
        .STEP_DIV (2),
        .MIN_DIV  (4),
        .DIV_W    (26)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Free-running clock and cycle counter used to timestamp go pulses
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        testsRun++;
        if (actual < lo || actual > hi) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, actual, lo, hi, cyc);
        end
    endtask

    // Monitor: one scoreboard entry per go; heading is checked the cycle after
    always @(negedge clk) begin
        if (rst) begin
            dirCheckDue = 1'b0;
        end else begin
            if (dirCheckDue) begin
                checkOutput("dirAfterGo", int'(ifc.dir), int'(dueDir));
                dirCheckDue = 1'b0;
            end
            if (ifc.go) begin
                goCount++;
                checkOutput("goOnlyWithReady", int'(ifc.ready), 1);
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedGo: got go=1 at cycle %0d, expected go=0", cyc);
                end else begin
                    expItem = sbQ.pop_front();
                    refC = (expItem.refCyc < 0) ? lastGoCyc : expItem.refCyc;
                    checkRange("goSpacing", cyc - refC, expItem.lo, expItem.hi);
                    dirCheckDue = 1'b1;
                    dueDir = expItem.dir;
                end
                lastGoCyc = cyc;
            end
        end
    end

    // Inputs always change just after the active edge
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) stepCycle();
    endtask

    task automatic applyStimulus(input logic up, input logic down, input logic left,
                                 input logic right, input logic pause);
        ifc.key_up    = up;
        ifc.key_down  = down;
        ifc.key_left  = left;
        ifc.key_right = right;
        ifc.key_pause = pause;
    endtask

    task automatic pushGo(input logic [1:0] dir, input int refCyc, input int lo, input int hi);
        goExp_t e;
        e.dir = dir;
        e.refCyc = refCyc;
        e.lo = lo;
        e.hi = hi;
        sbQ.push_back(e);
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n = 0;
        while (sbQ.size() != 0 && n < maxCycles) begin
            stepCycle();
            n++;
        end
        testsRun++;
        if (sbQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d go pulses outstanding after %0d cycles, expected 0",
                     name, sbQ.size(), maxCycles);
            sbQ.delete();
        end
    endtask

    task automatic applyReset();
        stepCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ifc.ready  = 1'b1;
        ifc.dead   = 1'b0;
        ifc.length = 11'd0;
        stepN(2);
        rst = 1'b0;
    endtask

    // Press a single key pattern for three cycles, then release everything
    task automatic tapKeys(input logic up, input logic down, input logic left,
                           input logic right, input logic pause);
        applyStimulus(up, down, left, right, pause);
        stepN(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int g0;
        int c2;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ifc.ready  = 1'b1;
        ifc.dead   = 1'b0;
        ifc.length = 11'd0;

        // Reset values, then idle with no keys, then the first key starts pacing
        applyReset();
        checkOutput("resetGo", int'(ifc.go), 0);
        checkOutput("resetDir", int'(ifc.dir), 3);
        checkOutput("resetPaused", int'(ifc.paused), 0);
        checkOutput("resetGameOver", int'(ifc.game_over), 0);
        g0 = goCount;
        stepN(100);
        checkOutput("idleNoGo", goCount - g0, 0);
        checkOutput("idleDir", int'(ifc.dir), 3);
        pushGo(2'd0, cyc, 20, 24);
        pushGo(2'd0, -1, 20, 20);
        tapKeys(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain("firstGoUp", 80);

        // Reverse request is dropped; up wins over left when both are held
        applyReset();
        pushGo(2'd3, cyc, 20, 24);
        pushGo(2'd3, -1, 20, 20);
        pushGo(2'd3, -1, 20, 20);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain("reverseDropped", 100);
        pushGo(2'd0, -1, 20, 20);
        pushGo(2'd0, -1, 20, 20);
        tapKeys(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        waitDrain("upBeatsLeft", 60);

        // Length-scaled spacing: old period finishes once after each change
        applyReset();
        pushGo(2'd3, cyc, 20, 24);
        pushGo(2'd3, -1, 20, 20);
        tapKeys(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDrain("length0", 80);
        ifc.length = 11'd5;
        pushGo(2'd3, -1, 20, 20);
        pushGo(2'd3, -1, 10, 10);
        pushGo(2'd3, -1, 10, 10);
        waitDrain("length5", 60);
        ifc.length = 11'd9;
        pushGo(2'd3, -1, 10, 10);
        pushGo(2'd3, -1, 4, 4);
        pushGo(2'd3, -1, 4, 4);
        waitDrain("length9Floor", 40);

        // Ready held low over three expiries: a single go when ready returns
        applyReset();
        pushGo(2'd3, cyc, 20, 24);
        tapKeys(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDrain("readyPrime", 80);
        ifc.ready = 1'b0;
        g0 = goCount;
        stepN(64);
        checkOutput("readyLowNoGo", goCount - g0, 0);
        pushGo(2'd3, cyc, 0, 0);
        ifc.ready = 1'b1;
        waitDrain("goWithReady", 5);

        // Pause with 7 counts left; the resume edge is seen 2 cycles after the
        // press and the remaining 7 counts then elapse before go
        applyReset();
        pushGo(2'd0, cyc, 20, 24);
        pushGo(2'd0, -1, 20, 20);
        tapKeys(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        waitDrain("pausePrime", 80);
        waitCycle(lastGoCyc + 11);
        tapKeys(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        g0 = goCount;
        stepN(50);
        checkOutput("pausedFlag", int'(ifc.paused), 1);
        checkOutput("pausedNoGo", goCount - g0, 0);
        c2 = cyc;
        pushGo(2'd0, c2, 9, 9);
        tapKeys(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        waitDrain("resumeGo", 20);
        checkOutput("resumedFlag", int'(ifc.paused), 0);

        // Collision while paused freezes everything until reset
        tapKeys(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        stepN(3);
        checkOutput("pausedBeforeDead", int'(ifc.paused), 1);
        ifc.dead = 1'b1;
        stepCycle();
        checkOutput("gameOverSet", int'(ifc.game_over), 1);
        checkOutput("pausedClearedByDead", int'(ifc.paused), 0);
        stepCycle();
        ifc.dead = 1'b0;
        g0 = goCount;
        for (int i = 0; i < 6; i++) begin
            tapKeys(i[0], i[1], 1'b0, 1'b1, 1'b1);
            stepN(7);
        end
        checkOutput("overNoGo", goCount - g0, 0);
        checkOutput("overHeld", int'(ifc.game_over), 1);
        checkOutput("overDir", int'(ifc.dir), 0);
        stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("rstGo", int'(ifc.go), 0);
        checkOutput("rstDir", int'(ifc.dir), 3);
        checkOutput("rstPaused", int'(ifc.paused), 0);
        checkOutput("rstGameOver", int'(ifc.game_over), 0);
        stepN(2);
        rst = 1'b0;

        // A go raised by ready is cut immediately by reset
        applyReset();
        pushGo(2'd3, cyc, 20, 24);
        tapKeys(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDrain("cutPrime", 80);
        ifc.ready = 1'b0;
        stepN(25);
        pushGo(2'd3, cyc, 0, 0);
        ifc.ready = 1'b1;
        #1;
        checkOutput("goInFlight", int'(ifc.go), 1);
        rst = 1'b1;
        #1;
        checkOutput("goCutByReset", int'(ifc.go), 0);
        checkOutput("dirCutByReset", int'(ifc.dir), 3);
        sbQ.delete();
        stepN(2);
        rst = 1'b0;
        stepN(5);

        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Watchdog so the bench always ends
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no completion by 1000000 ns, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
